// File: rtl/rpc2_ctrl_sync_fifo_prog.sv
// Single-clock FIFO for the RPC2 controller AXI data paths with optional first-word-fall-through,
// live fill count, programmable almost-full/almost-empty, synchronous flush and sticky error flags.
module rpc2_ctrl_sync_fifo_prog #(
  parameter int FIFO_ADDR_BITS  = 4,
  parameter int FIFO_DATA_WIDTH = 16,
  parameter bit FWFT            = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [FIFO_DATA_WIDTH-1:0] wr_data,
  input  logic                       rd_en,
  output logic [FIFO_DATA_WIDTH-1:0] rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [FIFO_ADDR_BITS:0]    count,
  input  logic [FIFO_ADDR_BITS:0]    af_thresh,
  input  logic [FIFO_ADDR_BITS:0]    ae_thresh,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int CW    = FIFO_ADDR_BITS + 1;
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam int IW    = (FIFO_ADDR_BITS > 0) ? FIFO_ADDR_BITS : 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [FIFO_DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0] wr_ptr, rd_ptr, mem_cnt, count_nxt;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          wr_acc, pop, load;
  logic          stage_valid, stage_valid_nxt, empty_nxt;

  // Pointers carry one extra wrap bit; the storage index is the pointer modulo DEPTH.
  if (FIFO_ADDR_BITS > 0) begin : g_idx
    assign wr_idx = wr_ptr[IW-1:0];
    assign rd_idx = rd_ptr[IW-1:0];
  end else begin : g_idx_single
    assign wr_idx = '0;
    assign rd_idx = '0;
  end

  assign mem_cnt = wr_ptr - rd_ptr;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    wr_acc          = wr_en & ~full & ~flush;
    pop             = rd_en & ~empty & ~flush;
    load            = pop;
    stage_valid_nxt = 1'b0;
    if (FWFT) begin
      // The output stage refills from storage whenever it is free or being popped this edge.
      load            = (mem_cnt != '0) & (~stage_valid | pop) & ~flush;
      stage_valid_nxt = ~flush & (load | (stage_valid & ~pop));
    end
    count_nxt = flush ? '0 : (count + CW'(wr_acc) - CW'(pop));
    empty_nxt = FWFT ? ~stage_valid_nxt : (count_nxt == '0);
  end

  // NOTE: the storage array has no reset; only pointers and flags define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      stage_valid  <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_data      <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
        if (load) begin
          rd_ptr  <= rd_ptr + CW'(1);
          rd_data <= mem[rd_idx];
        end
        // A new error event wins over a clear in the same cycle.
        if (wr_en & full)      overflow <= 1'b1;
        else if (clr_err)      overflow <= 1'b0;
        if (rd_en & empty)     underflow <= 1'b1;
        else if (clr_err)      underflow <= 1'b0;
      end
      stage_valid  <= stage_valid_nxt;
      count        <= count_nxt;
      empty        <= empty_nxt;
      full         <= (count_nxt == DEPTH_CNT);
      almost_full  <= (count_nxt >= af_thresh);
      almost_empty <= (count_nxt <= ae_thresh);
    end
  end

endmodule

// File: tb/tb_rpc2_ctrl_sync_fifo_prog.sv
// Drives a standard-mode and a first-word-fall-through instance with identical stimulus and
// compares both against queue-based reference models every cycle.
module tb_rpc2_ctrl_sync_fifo_prog;

  logic        clk = 1'b0;
  logic        rst, flush, wr_en, rd_en, clr_err;
  logic [15:0] wr_data;
  logic [4:0]  af_thresh, ae_thresh;

  logic [15:0] rd_data0, rd_data1;
  logic [4:0]  count0, count1;
  logic        empty0, full0, af0, ae0, ov0, un0;
  logic        empty1, full1, af1, ae1, ov1, un1;

  rpc2_ctrl_sync_fifo_prog #(.FIFO_ADDR_BITS(4), .FIFO_DATA_WIDTH(16), .FWFT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .empty(empty0), .full(full0), .count(count0),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .almost_full(af0), .almost_empty(ae0),
    .overflow(ov0), .underflow(un0), .clr_err(clr_err)
  );

  rpc2_ctrl_sync_fifo_prog #(.FIFO_ADDR_BITS(4), .FIFO_DATA_WIDTH(16), .FWFT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .empty(empty1), .full(full1), .count(count1),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .almost_full(af1), .almost_empty(ae1),
    .overflow(ov1), .underflow(un1), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference state: standard mode is one queue; FWFT mode is a queue plus a visible head slot.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  bit          sv1;
  logic [15:0] m_rd0, m_rd1;
  bit          m_ov0, m_un0, m_ae0, m_af0;
  bit          m_ov1, m_un1, m_ae1, m_af1;

  task automatic model_edge();
    bit full_pre, empty_pre, had;
    int n;
    if (rst) begin
      q0.delete(); q1.delete(); sv1 = 0;
      m_rd0 = '0; m_rd1 = '0;
      m_ov0 = 0; m_un0 = 0; m_ae0 = 1; m_af0 = 0;
      m_ov1 = 0; m_un1 = 0; m_ae1 = 1; m_af1 = 0;
      return;
    end
    full_pre  = (q0.size() == 16);
    empty_pre = (q0.size() == 0);
    if (flush) q0.delete();
    else begin
      if (wr_en && full_pre) m_ov0 = 1; else if (clr_err) m_ov0 = 0;
      if (rd_en && empty_pre) m_un0 = 1; else if (clr_err) m_un0 = 0;
      if (rd_en && !empty_pre) m_rd0 = q0.pop_front();
      if (wr_en && !full_pre) q0.push_back(wr_data);
    end
    n = q0.size();
    m_ae0 = (n <= int'(ae_thresh));
    m_af0 = (n >= int'(af_thresh));

    full_pre  = ((q1.size() + int'(sv1)) == 16);
    empty_pre = !sv1;
    if (flush) begin
      q1.delete(); sv1 = 0;
    end else begin
      if (wr_en && full_pre) m_ov1 = 1; else if (clr_err) m_ov1 = 0;
      if (rd_en && empty_pre) m_un1 = 1; else if (clr_err) m_un1 = 0;
      had = (q1.size() > 0);
      if (rd_en && sv1) sv1 = 0;
      if (had && !sv1) begin
        m_rd1 = q1.pop_front();
        sv1   = 1;
      end
      if (wr_en && !full_pre) q1.push_back(wr_data);
    end
    n = q1.size() + int'(sv1);
    m_ae1 = (n <= int'(ae_thresh));
    m_af1 = (n >= int'(af_thresh));
  endtask

  task automatic compare_all();
    int n0, n1;
    n0 = q0.size();
    n1 = q1.size() + int'(sv1);
    check("std_status", {count0, empty0, full0, ae0, af0, ov0, un0},
          {5'(n0), n0 == 0, n0 == 16, m_ae0, m_af0, m_ov0, m_un0});
    check("std_rd_data", rd_data0, m_rd0);
    check("fwft_status", {count1, empty1, full1, ae1, af1, ov1, un1},
          {5'(n1), !sv1, n1 == 16, m_ae1, m_af1, m_ov1, m_un1});
    check("fwft_rd_data", rd_data1, m_rd1);
  endtask

  task automatic step(input bit w, input logic [15:0] d, input bit r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step(1'b0, 16'h0, 1'b0);
    flush = 1'b0;
  endtask

  initial begin
    int bias;
    rst = 1'b1; flush = 1'b0; clr_err = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    af_thresh = 5'd12; ae_thresh = 5'd3;
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check("rst_status", {count0, empty0, full0, ae0, af0, ov0, un0}, 11'b00000_1_0_1_0_0_0);
    check("rst_rd_data", rd_data0, 16'h0000);
    check("rst_fwft_empty", empty1, 1'b1);
    rst = 1'b0;

    // Fill to full, then drain in order.
    for (int i = 1; i <= 16; i++) step(1'b1, 16'(i), 1'b0);
    check("t1_full", full0, 1'b1);
    check("t1_count", count0, 5'd16);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 16'h0, 1'b1);
      check("t1_rd_data", rd_data0, 16'(i));
    end
    check("t1_empty", empty0, 1'b1);

    // Write while full with a simultaneous read: read wins, write dropped.
    for (int i = 0; i < 16; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0);
    step(1'b1, 16'hBEEF, 1'b1);
    check("t2_count", count0, 5'd15);
    check("t2_overflow", ov0, 1'b1);
    check("t2_rd_data", rd_data0, 16'h0100);
    clr_err = 1'b1;
    step(1'b0, 16'h0, 1'b0);
    clr_err = 1'b0;
    check("t2_clr_err", ov0, 1'b0);

    // Read while empty.
    repeat (15) step(1'b0, 16'h0, 1'b1);
    check("t3_last_word", rd_data0, 16'h010F);
    step(1'b0, 16'h0, 1'b1);
    check("t3_underflow", un0, 1'b1);
    check("t3_rd_held", rd_data0, 16'h010F);
    step(1'b1, 16'h1234, 1'b1);
    check("t3_count", count0, 5'd1);
    check("t3_underflow_kept", un0, 1'b1);
    clr_err = 1'b1;
    step(1'b0, 16'h0, 1'b0);
    clr_err = 1'b0;

    // FWFT two-edge latency into the output stage.
    do_flush();
    step(1'b1, 16'hA5A5, 1'b0);
    check("t4_empty_after_1", empty1, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    check("t4_empty_after_2", empty1, 1'b0);
    check("t4_rd_data", rd_data1, 16'hA5A5);
    step(1'b0, 16'h0, 1'b1);
    check("t4_pop_empty", empty1, 1'b1);

    // Almost-full / almost-empty thresholds over a 0 -> 16 fill.
    af_thresh = 5'd12; ae_thresh = 5'd3;
    do_flush();
    check("t5_ae_at_0", ae0, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      step(1'b1, 16'($urandom), 1'b0);
      check("t5_almost_empty", ae0, c <= 3);
      check("t5_almost_full", af0, c >= 12);
    end

    // Steady-state pairs at count 8 across pointer wrap, then a flush mid-stream.
    do_flush();
    for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 16'($urandom), 1'b1);
    check("t6_count", count0, 5'd8);
    do_flush();
    check("t6_flush_std", {count0, empty0}, {5'd0, 1'b1});
    check("t6_flush_fwft", {count1, empty1}, {5'd0, 1'b1});

    // Randomised traffic with drifting write/read bias, flushes, clears, resets and threshold changes.
    bias = 2;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc % 64 == 0) bias = int'($urandom_range(1, 3));
      flush   = ($urandom_range(0, 59) == 0);
      clr_err = ($urandom_range(0, 29) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 49) == 0) begin
        af_thresh = 5'($urandom_range(0, 17));
        ae_thresh = 5'($urandom_range(0, 17));
      end
      step(int'($urandom_range(0, 3)) < bias, 16'($urandom), int'($urandom_range(0, 3)) < (4 - bias));
    end
    rst = 1'b0; flush = 1'b0; clr_err = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
